mult_arbiter: RTL and testbench

Shares one 8x8 unsigned multiplier between `N_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake; a round-robin arbiter grants one request at a time, the block computes the 16-bit product and returns it on a single response channel tagged with the requester index. It sits between the requesting datapath blocks and the team's existing `mult` multiplier, and is the only path by which that multiplier is reached.

---
 rtl/mult_arb_pkg.sv | 8 +
 rtl/mult_arbiter_if.sv | 29 ++
 rtl/mult.sv | 10 +
 rtl/mult_arbiter_rr_arb.sv | 25 ++
 rtl/mult_arbiter.sv | 86 ++++++++
 tb/tb_mult_arbiter.sv | 192 +++++++++++++++++++
 6 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and widths for the shared-multiplier arbiter.
package mult_arb_pkg;
    localparam int OPND_W = 8;
    localparam int PROD_W = 16;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;
endpackage

// File: rtl/mult_arbiter_if.sv
// Request/response bundle for mult_arbiter; grant_cnt exists only with MULT_ARB_CNT_EN.
interface mult_arbiter_if
    import mult_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0]             req_ready;
    logic [N_REQ-1:0][OPND_W-1:0] req_a;
    logic [N_REQ-1:0][OPND_W-1:0] req_b;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [ID_W-1:0]              rsp_id;
    logic [PROD_W-1:0]            rsp_x;
`ifdef MULT_ARB_CNT_EN
    logic [N_REQ-1:0][CNT_W-1:0]  grant_cnt;

    modport master (output req_valid, req_a, req_b, rsp_ready,
                    input  req_ready, rsp_valid, rsp_id, rsp_x, grant_cnt);
    modport slave  (input  req_valid, req_a, req_b, rsp_ready,
                    output req_ready, rsp_valid, rsp_id, rsp_x, grant_cnt);
`else
    modport master (output req_valid, req_a, req_b, rsp_ready,
                    input  req_ready, rsp_valid, rsp_id, rsp_x);
    modport slave  (input  req_valid, req_a, req_b, rsp_ready,
                    output req_ready, rsp_valid, rsp_id, rsp_x);
`endif
endinterface

// File: rtl/mult.sv
// Unsigned 8x8 -> 16 combinational multiplier shared by all requesters.
module mult
    import mult_arb_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [PROD_W-1:0] x
);
    assign x = {{(PROD_W-OPND_W){1'b0}}, a} * {{(PROD_W-OPND_W){1'b0}}, b};
endmodule

// File: rtl/mult_arbiter_rr_arb.sv
// Circular priority pick: first valid index at or after ptr, wrapping at N_REQ.
module rr_arb #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  grant,
    output logic             any
);
    logic [ID_W-1:0] idx;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!any && valid[idx]) begin
                grant = idx;
                any   = 1'b1;
            end
            idx = (idx == ID_W'(N_REQ-1)) ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: rtl/mult_arbiter.sv
// Round-robin access to one shared multiplier, one transaction in flight.
// Define MULT_ARB_CNT_EN to add per-requester accept counters (grant_cnt).
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input logic          clk,
    input logic          rst,
    mult_arbiter_if.slave bus
);
    state_e            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr, gnt, gnt_q;
    logic              any;
    logic              accept;
    logic [OPND_W-1:0] a_q, b_q;
    logic [PROD_W-1:0] prod;

    rr_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .valid (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (gnt),
        .any   (any)
    );

    mult u_mult (.a(a_q), .b(b_q), .x(prod));

    // Gating with rst keeps req_ready low during reset so no handshake can be seen.
    assign accept = (state == IDLE) && any && !rst;

    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        case (state)
            IDLE: if (accept) begin
                bus.req_ready[gnt] = 1'b1;
                state_nxt          = CALC;
            end
            CALC: state_nxt = RESP;
            RESP: if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            gnt_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_x     <= '0;
            bus.rsp_id    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (accept) begin
                    a_q    <= bus.req_a[gnt];
                    b_q    <= bus.req_b[gnt];
                    gnt_q  <= gnt;
                    rr_ptr <= (gnt == ID_W'(N_REQ-1)) ? '0 : gnt + 1'b1;
                end
                CALC: begin
                    bus.rsp_x     <= prod;
                    bus.rsp_id    <= gnt_q;
                    bus.rsp_valid <= 1'b1;
                end
                RESP: if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef MULT_ARB_CNT_EN
    logic [N_REQ-1:0][CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)         cnt      <= '0;
        else if (accept) cnt[gnt] <= cnt[gnt] + 1'b1;
    end

    assign bus.grant_cnt = cnt;
`endif
endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: stimulus pushes expected products, a monitor pops on response.
module tb_mult_arbiter;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();
    mult_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { int id; int x; int acc; } exp_t;
    typedef struct { int id; int cyc; } acc_t;
    exp_t sb[$];
    acc_t acc_log[$];
    int   exp_prod [N_REQ];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   seen   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: records handshakes (pushing the hand-computed product) and checks responses.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            chk("ready_onehot", int'($onehot0(bus.req_ready)), 1);
            chk("ready_wo_valid", int'(bus.req_ready & ~bus.req_valid), 0);
            for (int i = 0; i < N_REQ; i++)
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    sb.push_back('{i, exp_prod[i], cyc});
                    acc_log.push_back('{i, cyc});
                end
            if (bus.rsp_valid) begin
                chk("ready_busy", int'(bus.req_ready), 0);
                chk("rsp_has_exp", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    if (!seen) begin
                        chk("latency", cyc, sb[0].acc + 2);
                        seen = 1'b1;
                    end
                    chk("rsp_id", int'(bus.rsp_id), sb[0].id);
                    chk("rsp_x", int'(bus.rsp_x), sb[0].x);
                    if (bus.rsp_ready) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send(input int id, input int a, input int b, input int x);
        bus.req_a[id]     = 8'(a);
        bus.req_b[id]     = 8'(b);
        exp_prod[id]      = x;
        bus.req_valid[id] = 1'b1;
        #1;
        for (int k = 0; k < 20 && !bus.req_ready[id]; k++) step(1);
        chk("grant_wait", int'(bus.req_ready[id]), 1);
        step(1);
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && sb.size() != 0; k++) step(1);
        chk("drain", sb.size(), 0);
        step(1);
    endtask

    initial begin
        int order [6];
        int n0;
        order = '{0, 1, 2, 3, 0, 1};

        rst           = 1'b1;
        bus.req_valid = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        step(3);
        chk("rst_req_ready", int'(bus.req_ready), 0);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_rsp_x", int'(bus.rsp_x), 0);
        chk("rst_rsp_id", int'(bus.rsp_id), 0);
        bus.req_valid = '0;
        rst = 1'b0;
        step(1);

        // Single request, ready in the same cycle.
        bus.req_a[2] = 8'd12; bus.req_b[2] = 8'd13; exp_prod[2] = 156;
        bus.req_valid[2] = 1'b1;
        #1;
        chk("t1_ready", int'(bus.req_ready), 4);
        step(1);
        bus.req_valid[2] = 1'b0;
        drain();

        send(1, 255, 255, 65025); drain();
        send(0, 0, 200, 0);       drain();

        // Fairness from reset: all requesters hold valid.
        rst = 1'b1; step(1); rst = 1'b0;
        bus.req_a[0] = 8'd3;   bus.req_b[0] = 8'd5;  exp_prod[0] = 15;
        bus.req_a[1] = 8'd7;   bus.req_b[1] = 8'd9;  exp_prod[1] = 63;
        bus.req_a[2] = 8'd16;  bus.req_b[2] = 8'd16; exp_prod[2] = 256;
        bus.req_a[3] = 8'd200; bus.req_b[3] = 8'd2;  exp_prod[3] = 400;
        n0 = acc_log.size();
        bus.req_valid = '1;
        for (int k = 0; k < 40 && acc_log.size() < n0 + 6; k++) step(1);
        bus.req_valid = '0;
        chk("fair_count", int'(acc_log.size() >= n0 + 6), 1);
        if (acc_log.size() >= n0 + 6)
            for (int k = 0; k < 6; k++) begin
                chk("fair_order", acc_log[n0+k].id, order[k]);
                if (k > 0) chk("fair_spacing", acc_log[n0+k].cyc - acc_log[n0+k-1].cyc, 3);
            end
        drain();

        // Backpressure: hold RESP, a competing request must wait.
        bus.rsp_ready = 1'b0;
        send(3, 10, 20, 200);
        step(1);
        bus.req_a[0] = 8'd4; bus.req_b[0] = 8'd5; exp_prod[0] = 20;
        bus.req_valid[0] = 1'b1;
        step(5);
        chk("bp_valid_held", int'(bus.rsp_valid), 1);
        chk("bp_no_ready", int'(bus.req_ready), 0);
        bus.rsp_ready = 1'b1;
        step(1);
        chk("bp_next_grant", int'(bus.req_ready), 1);
        step(1);
        bus.req_valid[0] = 1'b0;
        drain();

        // Reset during CALC discards the transaction and clears rr_ptr.
        send(1, 6, 7, 42);
        rst = 1'b1; step(1); rst = 1'b0;
        sb.delete();
        seen = 1'b0;
        step(4);
        chk("rst_no_rsp", int'(bus.rsp_valid), 0);
        bus.req_a[3] = 8'd9; bus.req_b[3] = 8'd9; exp_prod[3] = 81;
        bus.req_a[0] = 8'd8; bus.req_b[0] = 8'd8; exp_prod[0] = 64;
        bus.req_valid[3] = 1'b1; bus.req_valid[0] = 1'b1;
        #1;
        chk("rst_grant0", int'(bus.req_ready), 1);
        step(1);
        bus.req_valid[0] = 1'b0;
        for (int k = 0; k < 20 && !bus.req_ready[3]; k++) step(1);
        chk("rst_grant3", int'(bus.req_ready[3]), 1);
        step(1);
        bus.req_valid[3] = 1'b0;
        drain();

`ifdef MULT_ARB_CNT_EN
        rst = 1'b1; step(1); rst = 1'b0;
        chk("cnt_rst", int'(bus.grant_cnt[1]), 0);
        send(1, 1, 2, 2); drain();
        send(1, 3, 4, 12); drain();
        send(0, 5, 6, 30); drain();
        send(1, 7, 8, 56); drain();
        chk("cnt_slice1", int'(bus.grant_cnt[1]), 3);
        chk("cnt_slice0", int'(bus.grant_cnt[0]), 1);
        dut.cnt[2] = 16'hFFFF;
        send(2, 2, 2, 4); drain();
        chk("cnt_wrap", int'(bus.grant_cnt[2]), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
